// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: shared types and constants for the multi-cycle data-memory responder.
//   state_t    : responder FSM states
//   op_t       : captured operation kind
//   WORD_BYTES : bytes per storage word
//   ADDR_LSB   : low byte-address bits dropped to form the word index
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB = $clog2(WORD_BYTES);
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write and combinational read; not reset.
//   clk_i   : clock
//   we_i    : write enable
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : read data at idx_i
module dmem_array #(
  parameter int DEPTH = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem[idx_i] <= wdata_i;
  assign rdata_o = mem[idx_i];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle MEM-stage load/store responder with fixed latency and error reporting.
//   clk_i, rst_n      : clock, async active-low reset
//   req_read_i/write_i: load/store request
//   addr_i, wdata_i   : byte address, store data
//   rdata_o           : load data, registered on completion
//   ready_o, err_o    : one-cycle completion pulse and its error flag
//   stall_o           : combinational pipeline hold
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stall_o
);
  localparam int CW = $clog2(LATENCY + 1);
  state_t         state;
  op_t            op;
  logic [AW-1:0]  idx;
  logic [31:0]    wd;
  logic           err_q;
  logic [CW-1:0]  cnt;
  logic           req, req_err, enter_done, we;
  logic [AW-1:0]  cur_idx;
  logic [31:0]    cur_wdata, arr_rdata;
  op_t            cur_op;
  logic           cur_err;
  assign req     = req_read_i | req_write_i;
  assign req_err = (|addr_i[ADDR_LSB-1:0]) | (|addr_i[31:AW+ADDR_LSB]) | (req_read_i & req_write_i);
  assign stall_o = (state == IDLE && req) || state == WAIT;
  // With LATENCY=1 the capture edge is also the commit edge, so the live
  // inputs stand in for the not-yet-captured registers while in IDLE.
  assign cur_idx    = state == IDLE ? addr_i[AW+ADDR_LSB-1:ADDR_LSB] : idx;
  assign cur_wdata  = state == IDLE ? wdata_i : wd;
  assign cur_op     = state == IDLE ? (req_write_i ? OP_WR : OP_RD) : op;
  assign cur_err    = state == IDLE ? req_err : err_q;
  assign enter_done = (state == IDLE && req && LATENCY == 1) || (state == WAIT && cnt == '0);
  assign we         = enter_done && cur_op == OP_WR && !cur_err;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (we),
    .idx_i   (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (arr_rdata)
  );
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      op      <= OP_RD;
      idx     <= '0;
      wd      <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_o <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ready_o <= enter_done;
      err_o   <= enter_done & cur_err;
      if (enter_done) rdata_o <= cur_err ? '0 : arr_rdata;
      case (state)
        IDLE: if (req) begin
          op    <= req_write_i ? OP_WR : OP_RD;
          idx   <= addr_i[AW+ADDR_LSB-1:ADDR_LSB];
          wd    <= wdata_i;
          err_q <= req_err;
          cnt   <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
          state <= LATENCY == 1 ? DONE : WAIT;
        end
        WAIT: if (cnt == '0) state <= DONE;
              else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench over LATENCY=2, 1 and 4 instances.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rr [3];
  logic        ww [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        err [3];
  logic        stall [3];
  int          passed = 0;
  int          total = 0;
  int          lat_of [3] = '{2, 1, 4};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_n(rst_n), .req_read_i(rr[0]), .req_write_i(ww[0]), .addr_i(ad[0]),
    .wdata_i(wd[0]), .rdata_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0]), .stall_o(stall[0]));
  dmem_responder #(.DEPTH(128), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_n(rst_n), .req_read_i(rr[1]), .req_write_i(ww[1]), .addr_i(ad[1]),
    .wdata_i(wd[1]), .rdata_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1]), .stall_o(stall[1]));
  dmem_responder #(.DEPTH(128), .LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_n(rst_n), .req_read_i(rr[2]), .req_write_i(ww[2]), .addr_i(ad[2]),
    .wdata_i(wd[2]), .rdata_o(rdata[2]), .ready_o(ready[2]), .err_o(err[2]), .stall_o(stall[2]));

  // Presents a request from the next cycle until ready_o is seen (bounded);
  // returns stall cycles seen (ready cycle included), the ready cycle index, data and error.
  task automatic xact(input int u, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int stalls, output int lat,
                      output logic [31:0] q, output logic e);
    @(posedge clk); #1;
    rr[u] = r; ww[u] = w; ad[u] = a; wd[u] = d;
    stalls = 0; lat = -1; q = 'x; e = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall[u]) stalls++;
      if (ready[u]) begin
        lat = c; q = rdata[u]; e = err[u];
        break;
      end
    end
  endtask

  task automatic go_idle(input int u);
    @(posedge clk); #1;
    rr[u] = 1'b0; ww[u] = 1'b0;
  endtask

  task automatic test_reset;
    for (int u = 0; u < 3; u++) begin
      rr[u] = 1'b0; ww[u] = 1'b0; ad[u] = '0; wd[u] = '0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      total++;
      if ({ready[u], err[u], stall[u], rdata[u]} !== 35'd0)
        $display("FAIL reset u%0d: ready=%b err=%b stall=%b rdata=%h, want all 0", u, ready[u], err[u], stall[u], rdata[u]);
      else passed++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    int s, l; logic [31:0] q; logic e;
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, s, l, q, e);
    total++;
    if (s !== 2 || l !== 2 || e !== 1'b0) $display("FAIL wr_store: stalls=%0d lat=%0d err=%b, want 2 2 0", s, l, e);
    else passed++;
    xact(0, 1, 0, 32'h10, 32'h0, s, l, q, e);
    total++;
    if (s !== 2 || l !== 2 || e !== 1'b0 || q !== 32'hDEADBEEF)
      $display("FAIL wr_load: stalls=%0d lat=%0d err=%b rdata=%h, want 2 2 0 deadbeef", s, l, e, q);
    else passed++;
    @(negedge clk);
    total++;
    if (ready[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF)
      $display("FAIL wr_hold: ready=%b rdata=%h, want 0 deadbeef", ready[0], rdata[0]);
    else passed++;
    go_idle(0);
  endtask

  task automatic test_back_to_back;
    int s, l; logic [31:0] q; logic e;
    logic [31:0] vals [3] = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
    for (int i = 0; i < 3; i++) begin
      xact(1, 0, 1, 32'(i * 4), vals[i], s, l, q, e);
      total++;
      if (s !== 1 || l !== 1 || e !== 1'b0) $display("FAIL b2b_store%0d: stalls=%0d lat=%0d err=%b, want 1 1 0", i, s, l, e);
      else passed++;
    end
    go_idle(1);
    for (int i = 0; i < 3; i++) begin
      xact(1, 1, 0, 32'(i * 4), 32'h0, s, l, q, e);
      total++;
      if (l !== 1 || e !== 1'b0 || q !== vals[i]) $display("FAIL b2b_load%0d: lat=%0d err=%b rdata=%h, want 1 0 %h", i, l, e, q, vals[i]);
      else passed++;
    end
    go_idle(1);
  endtask

  task automatic test_misaligned;
    int s, l; logic [31:0] q; logic e;
    xact(0, 0, 1, 32'h4, 32'h0BADF00D, s, l, q, e);
    xact(0, 0, 1, 32'h6, 32'h12345678, s, l, q, e);
    total++;
    if (l !== 2 || e !== 1'b1) $display("FAIL mis_store: lat=%0d err=%b, want 2 1", l, e);
    else passed++;
    xact(0, 1, 0, 32'h6, 32'h0, s, l, q, e);
    total++;
    if (l !== 2 || e !== 1'b1 || q !== 32'h0) $display("FAIL mis_load: lat=%0d err=%b rdata=%h, want 2 1 0", l, e, q);
    else passed++;
    xact(0, 1, 0, 32'h4, 32'h0, s, l, q, e);
    total++;
    if (e !== 1'b0 || q !== 32'h0BADF00D) $display("FAIL mis_word1: err=%b rdata=%h, want 0 0badf00d", e, q);
    else passed++;
    go_idle(0);
  endtask

  task automatic test_range_conflict;
    int s, l; logic [31:0] q; logic e;
    xact(0, 1, 0, 32'h200, 32'h0, s, l, q, e);
    total++;
    if (s !== 2 || l !== 2 || e !== 1'b1 || q !== 32'h0) $display("FAIL range: stalls=%0d lat=%0d err=%b rdata=%h, want 2 2 1 0", s, l, e, q);
    else passed++;
    xact(0, 1, 1, 32'h10, 32'h55555555, s, l, q, e);
    total++;
    if (l !== 2 || e !== 1'b1 || q !== 32'h0) $display("FAIL conflict: lat=%0d err=%b rdata=%h, want 2 1 0", l, e, q);
    else passed++;
    xact(0, 1, 0, 32'h10, 32'h0, s, l, q, e);
    total++;
    if (e !== 1'b0 || q !== 32'hDEADBEEF) $display("FAIL conflict_nowrite: err=%b rdata=%h, want 0 deadbeef", e, q);
    else passed++;
    go_idle(0);
  endtask

  task automatic test_drop_in_wait;
    int s, l; logic [31:0] q; logic e;
    logic [5:0] st, rd;
    @(posedge clk); #1;
    ww[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'hA5A5A5A5;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) begin ww[2] = 1'b0; ad[2] = 32'hFFFFFFFF; wd[2] = 32'h0; end
      end
      @(negedge clk);
      st[c] = stall[2]; rd[c] = ready[2];
    end
    total++;
    if (st !== 6'b001111 || rd !== 6'b010000) $display("FAIL drop_timing: stall=%b ready=%b, want 001111 010000", st, rd);
    else passed++;
    xact(2, 1, 0, 32'h20, 32'h0, s, l, q, e);
    total++;
    if (s !== 4 || l !== 4 || e !== 1'b0 || q !== 32'hA5A5A5A5)
      $display("FAIL drop_load: stalls=%0d lat=%0d err=%b rdata=%h, want 4 4 0 a5a5a5a5", s, l, e, q);
    else passed++;
    go_idle(2);
  endtask

  task automatic test_reset_mid;
    int s, l; logic [31:0] q; logic e;
    xact(2, 0, 1, 32'h30, 32'h11111111, s, l, q, e);
    xact(2, 1, 0, 32'h30, 32'h0, s, l, q, e);
    total++;
    if (q !== 32'h11111111) $display("FAIL rst_pre: rdata=%h, want 11111111", q);
    else passed++;
    @(posedge clk); #1;
    rr[2] = 1'b0; ww[2] = 1'b1; ad[2] = 32'h30; wd[2] = 32'h22222222;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0; ww[2] = 1'b0;
    #1;
    total++;
    if ({ready[2], err[2], stall[2], rdata[2]} !== 35'd0)
      $display("FAIL rst_mid: ready=%b err=%b stall=%b rdata=%h, want all 0", ready[2], err[2], stall[2], rdata[2]);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    xact(2, 1, 0, 32'h30, 32'h0, s, l, q, e);
    total++;
    if (l !== 4 || e !== 1'b0 || q !== 32'h11111111) $display("FAIL rst_post: lat=%0d err=%b rdata=%h, want 4 0 11111111", l, e, q);
    else passed++;
    go_idle(2);
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_misaligned;
    test_range_conflict;
    test_drop_in_wait;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
